// File: rtl/prime_range_scanner.sv
// Iterative prime enumerator: scans [lo, hi] by trial division, one divisor
// per cycle, and streams each prime found over a valid/ready handshake.
module prime_range_scanner #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] lo,
  input  logic [N-1:0] hi,
  output logic         busy,
  output logic         done,
  output logic         p_valid,
  input  logic         p_ready,
  output logic [N-1:0] p_data,
  output logic [N-1:0] count
);

  localparam int unsigned W2 = 2 * N;

  typedef enum logic [2:0] {IDLE, TEST, EMIT, NEXT, DONE} state_t;

  state_t         state, state_nx;
  logic [N-1:0]   cand, cand_nx;
  logic [N-1:0]   d, d_nx;
  logic [N-1:0]   hi_q, hi_nx;
  logic [N-1:0]   count_nx;
  logic [N-1:0]   p_data_nx;
  logic [W2-1:0]  d_sq;
  logic           divides;

  // Square is formed at double width so d*d > cand never overflows.
  assign d_sq    = W2'(d) * W2'(d);
  assign divides = (cand % d) == '0;

  // Next-state and datapath updates.
  always_comb begin
    state_nx  = state;
    cand_nx   = cand;
    d_nx      = d;
    hi_nx     = hi_q;
    count_nx  = count;
    p_data_nx = p_data;
    case (state)
      IDLE: begin
        if (start) begin
          hi_nx    = hi;
          cand_nx  = lo;
          d_nx     = N'(2);
          count_nx = '0;
          state_nx = (hi < lo) ? DONE : TEST;
        end
      end
      TEST: begin
        if (cand < N'(2)) begin
          state_nx = NEXT;
        end else if (d_sq > W2'(cand)) begin
          state_nx  = EMIT;
          p_data_nx = cand;
        end else if (divides) begin
          state_nx = NEXT;
        end else begin
          d_nx = d + N'(1);
        end
      end
      EMIT: begin
        if (p_ready) begin
          count_nx = count + N'(1);
          state_nx = NEXT;
        end
      end
      NEXT: begin
        // Compare before incrementing so hi = 2^N-1 ends without wrapping.
        if (cand == hi_q) begin
          state_nx = DONE;
        end else begin
          cand_nx  = cand + N'(1);
          d_nx     = N'(2);
          state_nx = TEST;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, datapath and registered outputs (decoded from the next state).
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cand    <= '0;
      d       <= N'(2);
      hi_q    <= '0;
      count   <= '0;
      p_data  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      p_valid <= 1'b0;
    end else begin
      state   <= state_nx;
      cand    <= cand_nx;
      d       <= d_nx;
      hi_q    <= hi_nx;
      count   <= count_nx;
      p_data  <= p_data_nx;
      busy    <= state_nx != IDLE;
      done    <= state_nx == DONE;
      p_valid <= state_nx == EMIT;
    end
  end

endmodule

// File: tb/tb_prime_range_scanner.sv
// Self-checking bench for prime_range_scanner: vector table, hand-written
// timing corners and randomized scans against a plain-arithmetic prime model.
module tb_prime_range_scanner;

  logic       clk = 1'b0;
  logic       rst, start, p_ready, busy, done, p_valid;
  logic [7:0] lo, hi, p_data, count;
  logic       start4, p_ready4, busy4, done4, p_valid4;
  logic [3:0] lo4, hi4, p_data4, count4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int lo;
    int hi;
    int bp;
    int restart;
    int exp_count;
  } vec_t;

  vec_t tbl[7];

  always #5 clk = ~clk;

  prime_range_scanner #(.N(8)) dut (
    .clk(clk), .rst(rst), .start(start), .lo(lo), .hi(hi),
    .busy(busy), .done(done), .p_valid(p_valid), .p_ready(p_ready),
    .p_data(p_data), .count(count)
  );

  prime_range_scanner #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .lo(lo4), .hi(hi4),
    .busy(busy4), .done(done4), .p_valid(p_valid4), .p_ready(p_ready4),
    .p_data(p_data4), .count(count4)
  );

  function automatic bit is_prime(input int v);
    if (v < 2) return 1'b0;
    for (int k = 2; k * k <= v; k++)
      if (v % k == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One full scan with random backpressure; optional extra start while busy.
  task automatic run_scan(input int l, input int h, input int bp,
                          input int restart, input int exp_count);
    int exp_q[$];
    int got[$];
    bit stall;
    bit fin;
    int held;
    int done_cyc;
    stall = 1'b0;
    fin = 1'b0;
    held = 0;
    done_cyc = -1;
    for (int v = l; v <= h; v++)
      if (is_prime(v)) exp_q.push_back(v);
    @(negedge clk);
    lo = 8'(l);
    hi = 8'(h);
    start = 1'b1;
    p_ready = 1'b0;
    for (int cyc = 0; cyc < 6000 && !fin; cyc++) begin
      @(negedge clk);
      start = (cyc == restart);
      if (stall) begin
        check("hold_valid", int'(p_valid), 1);
        check("hold_data", int'(p_data), held);
      end
      if (done) begin
        fin = 1'b1;
        done_cyc = cyc;
        check("count_model", int'(count), exp_q.size());
      end
      p_ready = (int'($urandom_range(99)) >= bp);
      if (p_valid && p_ready) got.push_back(int'(p_data));
      stall = p_valid && !p_ready;
      held = int'(p_data);
    end
    start = 1'b0;
    check("scan_timeout", int'(fin), 1);
    check("stream_len", got.size(), exp_q.size());
    if (got.size() == exp_q.size())
      for (int i = 0; i < got.size(); i++) check("stream_val", got[i], exp_q[i]);
    if (exp_count >= 0) check("count_tbl", int'(count), exp_count);
    if (h < l) check("empty_done_latency", done_cyc, 0);
    @(negedge clk);
    p_ready = 1'b0;
    check("done_pulse_width", int'(done), 0);
    check("busy_after_done", int'(busy), 0);
    @(negedge clk);
    check("idle_stays", int'(busy), 0);
    check("count_hold", int'(count), exp_q.size());
  endtask

  initial begin
    int vc;
    int l;
    int h;
    bit seen;
    int got4[$];
    int exp4[$];

    tbl[0] = '{lo: 2,   hi: 3,   bp: 0,  restart: -1, exp_count: 2};
    tbl[1] = '{lo: 9,   hi: 4,   bp: 0,  restart: -1, exp_count: 0};
    tbl[2] = '{lo: 0,   hi: 1,   bp: 0,  restart: 2,  exp_count: 0};
    tbl[3] = '{lo: 100, hi: 120, bp: 30, restart: -1, exp_count: 5};
    tbl[4] = '{lo: 250, hi: 255, bp: 20, restart: -1, exp_count: 1};
    tbl[5] = '{lo: 0,   hi: 255, bp: 0,  restart: -1, exp_count: 54};
    tbl[6] = '{lo: 2,   hi: 2,   bp: 50, restart: -1, exp_count: 1};

    rst = 1'b1; start = 1'b0; p_ready = 1'b0; lo = '0; hi = '0;
    start4 = 1'b0; p_ready4 = 1'b0; lo4 = '0; hi4 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_valid", int'(p_valid), 0);
    check("rst_data", int'(p_data), 0);
    check("rst_count", int'(count), 0);
    rst = 1'b0;

    // Exact cycle timing for lo=hi=2.
    @(negedge clk);
    lo = 8'd2; hi = 8'd2; start = 1'b1; p_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t1_busy", int'(busy), 1);
    check("t1_valid", int'(p_valid), 0);
    @(negedge clk);
    check("t2_valid", int'(p_valid), 1);
    check("t2_data", int'(p_data), 2);
    @(negedge clk);
    check("t3_valid", int'(p_valid), 0);
    check("t3_count", int'(count), 1);
    check("t3_done", int'(done), 0);
    @(negedge clk);
    check("t4_done", int'(done), 1);
    check("t4_busy", int'(busy), 1);
    @(negedge clk);
    check("t5_done", int'(done), 0);
    check("t5_busy", int'(busy), 0);

    for (int i = 0; i < 7; i++)
      run_scan(tbl[i].lo, tbl[i].hi, tbl[i].bp, tbl[i].restart, tbl[i].exp_count);

    // Backpressure: lo=hi=5, p_ready low for five valid cycles.
    @(negedge clk);
    lo = 8'd5; hi = 8'd5; start = 1'b1; p_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      seen = p_valid;
    end
    check("bp_valid_seen", int'(seen), 1);
    vc = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (p_valid && p_data == 8'd5) vc++;
      p_ready = (i == 5);
    end
    @(negedge clk);
    check("bp_valid_cycles", vc, 6);
    check("bp_valid_drop", int'(p_valid), 0);
    check("bp_count", int'(count), 1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check("bp_done", int'(seen), 1);
    check("bp_count_final", int'(count), 1);
    p_ready = 1'b0;

    // N=4 full range: must stop at 15 without wrapping back to 0.
    for (int v = 0; v <= 15; v++) if (is_prime(v)) exp4.push_back(v);
    @(negedge clk);
    lo4 = 4'd0; hi4 = 4'd15; start4 = 1'b1; p_ready4 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (p_valid4) got4.push_back(int'(p_data4));
      seen = done4;
    end
    check("n4_done", int'(seen), 1);
    check("n4_count", int'(count4), 6);
    check("n4_len", got4.size(), exp4.size());
    if (got4.size() == exp4.size())
      for (int i = 0; i < got4.size(); i++) check("n4_val", got4[i], exp4[i]);
    repeat (3) @(negedge clk);
    check("n4_no_wrap", int'(busy4), 0);

    // Reset while a prime is pending in EMIT, with start coincident with reset.
    @(negedge clk);
    lo = 8'd90; hi = 8'd100; start = 1'b1; p_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      seen = p_valid;
    end
    check("rm_valid_seen", int'(seen), 1);
    check("rm_data", int'(p_data), 97);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check("rm_busy", int'(busy), 0);
    check("rm_done", int'(done), 0);
    check("rm_valid", int'(p_valid), 0);
    check("rm_data0", int'(p_data), 0);
    check("rm_count", int'(count), 0);
    @(negedge clk);
    check("rm_start_dropped", int'(busy), 0);
    run_scan(97, 97, 0, -1, 1);

    // Randomized scans, including some empty ranges.
    for (int it = 0; it < 25; it++) begin
      l = int'($urandom_range(255));
      if ($urandom_range(7) == 0 && l > 0) begin
        h = int'($urandom_range(l - 1));
      end else begin
        h = l + int'($urandom_range(30));
        if (h > 255) h = 255;
      end
      run_scan(l, h, int'($urandom_range(60)), -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
